mvu_irq_ctrl: RTL and testbench

- Pito-side responder for the MVU job handshake.
- Pito harts launch one job per MVU via mvu_start; each MVU returns a mvu_done pulse.
- This block tracks every MVU's job lifecycle, raises a per-hart interrupt on completion or watchdog timeout, and holds it until the owning hart acknowledges.
- Sits between the MVU array and pito's interrupt/CSR logic inside accelerator.

---
 rtl/mvu_irq_pkg.sv | 23 ++
 rtl/mvu_irq_channel.sv | 151 +++++++++++++++
 rtl/mvu_irq_ctrl.sv | 43 ++++
 tb/tb_mvu_irq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_irq_pkg.sv
// Shared types and helpers for the MVU job-handshake interrupt controller.
package mvu_irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_BUSY    = 2'd1,
        IRQ_PENDING = 2'd2
    } irq_state_t;

    // Watchdog counter width. A disabled watchdog (limit 0) still gets one bit
    // so the register declaration stays legal.
    function automatic int wd_width(input int timeout_cyc);
        int w;
        w = $clog2(timeout_cyc + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mvu_irq_channel.sv
// One MVU/hart channel: job lifecycle FSM, watchdog, completed-job counter
// and sticky protocol-error flags. All outputs come straight from flops.
module mvu_irq_channel
    import mvu_irq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65536,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             done_i,
    input  logic             ack_i,
    input  logic             err_clr_i,
    output logic             busy_o,
    output logic             irq_o,
    output logic             timeout_o,
    output logic             err_spurious_o,
    output logic             err_restart_o,
    output logic [CNT_W-1:0] job_cnt_o
);

    localparam int WD_W = wd_width(TIMEOUT_CYC);

    irq_state_t        state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, irq_q;
    logic              tmo_q, tmo_d;
    logic              spur_q, spur_d;
    logic              rstrt_q, rstrt_d;
    logic              spur_set_s;
    logic              rstrt_set_s;
    logic              wd_expire_s;

    // The watchdog only fires when enabled and the busy count hits the limit.
    assign wd_expire_s = (TIMEOUT_CYC != 0) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    // Next-state logic for the job FSM, watchdog, counter and error sets.
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        spur_set_s  = 1'b0;
        rstrt_set_s = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (start_i) begin
                    state_d = IRQ_BUSY;
                    wd_d    = '0;
                    tmo_d   = 1'b0;
                end else begin
                    state_d = IRQ_IDLE;
                end
                if (done_i) begin
                    spur_set_s = 1'b1;
                end else begin
                    spur_set_s = 1'b0;
                end
            end
            IRQ_BUSY: begin
                wd_d = wd_q + WD_W'(1);
                // A real completion beats a coincident watchdog expiry.
                if (done_i) begin
                    state_d = IRQ_PENDING;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (wd_expire_s) begin
                    state_d = IRQ_PENDING;
                    tmo_d   = 1'b1;
                end else begin
                    state_d = IRQ_BUSY;
                end
                if (start_i) begin
                    rstrt_set_s = 1'b1;
                end else begin
                    rstrt_set_s = 1'b0;
                end
            end
            IRQ_PENDING: begin
                // ack together with start is the back-to-back relaunch.
                if (ack_i && start_i) begin
                    state_d = IRQ_BUSY;
                    wd_d    = '0;
                    tmo_d   = 1'b0;
                end else if (ack_i) begin
                    state_d = IRQ_IDLE;
                end else if (start_i) begin
                    rstrt_set_s = 1'b1;
                end else begin
                    state_d = IRQ_PENDING;
                end
                if (done_i) begin
                    spur_set_s = 1'b1;
                end else begin
                    spur_set_s = 1'b0;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase

        // Sticky flags: a new error in the clearing cycle survives the clear.
        if (spur_set_s) begin
            spur_d = 1'b1;
        end else if (err_clr_i) begin
            spur_d = 1'b0;
        end else begin
            spur_d = spur_q;
        end
        if (rstrt_set_s) begin
            rstrt_d = 1'b1;
        end else if (err_clr_i) begin
            rstrt_d = 1'b0;
        end else begin
            rstrt_d = rstrt_q;
        end
    end

    // State and output registers; reset drops any job without an interrupt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IRQ_IDLE;
            wd_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            irq_q   <= 1'b0;
            tmo_q   <= 1'b0;
            spur_q  <= 1'b0;
            rstrt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == IRQ_BUSY);
            irq_q   <= (state_d == IRQ_PENDING);
            tmo_q   <= tmo_d;
            spur_q  <= spur_d;
            rstrt_q <= rstrt_d;
        end
    end

    assign busy_o         = busy_q;
    assign irq_o          = irq_q;
    assign timeout_o      = tmo_q;
    assign err_spurious_o = spur_q;
    assign err_restart_o  = rstrt_q;
    assign job_cnt_o      = cnt_q;

endmodule

// File: rtl/mvu_irq_ctrl.sv
// Pito-side MVU job responder: one independent interrupt channel per MVU/hart.
module mvu_irq_ctrl
    import mvu_irq_pkg::*;
#(
    parameter int N_MVU       = 8,
    parameter int TIMEOUT_CYC = 65536,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_MVU-1:0]       mvu_start,
    input  logic [N_MVU-1:0]       mvu_done,
    input  logic [N_MVU-1:0]       irq_ack,
    input  logic [N_MVU-1:0]       err_clr,
    output logic [N_MVU-1:0]       mvu_busy,
    output logic [N_MVU-1:0]       mvu_irq,
    output logic [N_MVU-1:0]       mvu_timeout,
    output logic [N_MVU-1:0]       err_spurious,
    output logic [N_MVU-1:0]       err_restart,
    output logic [N_MVU*CNT_W-1:0] job_cnt
);

    for (genvar g = 0; g < N_MVU; g++) begin : g_ch
        mvu_irq_channel #(
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk_i          (clk),
            .rst_i          (rst),
            .start_i        (mvu_start[g]),
            .done_i         (mvu_done[g]),
            .ack_i          (irq_ack[g]),
            .err_clr_i      (err_clr[g]),
            .busy_o         (mvu_busy[g]),
            .irq_o          (mvu_irq[g]),
            .timeout_o      (mvu_timeout[g]),
            .err_spurious_o (err_spurious[g]),
            .err_restart_o  (err_restart[g]),
            .job_cnt_o      (job_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_mvu_irq_ctrl.sv
// Directed scoreboard bench for mvu_irq_ctrl (watchdog 16 cycles, 4-bit counters).
module tb_mvu_irq_ctrl;

    localparam int N   = 8;
    localparam int TMO = 16;
    localparam int CW  = 4;

    localparam int S_BUSY = 0;
    localparam int S_IRQ  = 1;
    localparam int S_TMO  = 2;
    localparam int S_SPUR = 3;
    localparam int S_RST  = 4;
    localparam int S_CNT  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    mvu_start, mvu_done, irq_ack, err_clr;
    logic [N-1:0]    mvu_busy, mvu_irq, mvu_timeout, err_spurious, err_restart;
    logic [N*CW-1:0] job_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt_m[N];
    logic [N-1:0] busy_m, irq_m;

    mvu_irq_ctrl #(.N_MVU(N), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .mvu_start    (mvu_start),
        .mvu_done     (mvu_done),
        .irq_ack      (irq_ack),
        .err_clr      (err_clr),
        .mvu_busy     (mvu_busy),
        .mvu_irq      (mvu_irq),
        .mvu_timeout  (mvu_timeout),
        .err_spurious (err_spurious),
        .err_restart  (err_restart),
        .job_cnt      (job_cnt)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_bi(input string tag, input logic [N-1:0] b, input logic [N-1:0] i);
        push({tag, "_busy"}, S_BUSY, 32'(b));
        push({tag, "_irq"}, S_IRQ, 32'(i));
    endtask

    task automatic push_cnt(input string tag, input int ch);
        push($sformatf("%s_cnt%0d", tag, ch), S_CNT + ch, 32'(cnt_m[ch]));
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_BUSY:  return 32'(mvu_busy);
            S_IRQ:   return 32'(mvu_irq);
            S_TMO:   return 32'(mvu_timeout);
            S_SPUR:  return 32'(err_spurious);
            S_RST:   return 32'(err_restart);
            default: return 32'(job_cnt[(sel-S_CNT)*CW +: CW]);
        endcase
    endfunction

    // One clock; strobes are cleared after the edge that consumed them.
    task automatic tick();
        @(posedge clk);
        #1;
        mvu_start = '0;
        mvu_done  = '0;
        irq_ack   = '0;
        err_clr   = '0;
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            n_cmp++;
            assert (o === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic step();
        tick();
        check();
    endtask

    task automatic push_all_zero(input string tag);
        push_bi(tag, 8'h00, 8'h00);
        push({tag, "_tmo"}, S_TMO, 32'd0);
        push({tag, "_spur"}, S_SPUR, 32'd0);
        push({tag, "_rst"}, S_RST, 32'd0);
        for (int c = 0; c < N; c++) begin
            cnt_m[c] = 0;
            push_cnt(tag, c);
        end
    endtask

    initial begin
        rst = 1'b1;
        mvu_start = '0; mvu_done = '0; irq_ack = '0; err_clr = '0;
        tick();
        push_all_zero("reset");
        step();
        rst = 1'b0;

        // Basic job on channel 3: busy 15 cycles, irq held until ack.
        repeat (3) tick();
        mvu_start[3] = 1'b1;
        push_bi("t1_start", 8'h08, 8'h00);
        step();
        repeat (14) begin
            push_bi("t1_run", 8'h08, 8'h00);
            step();
        end
        mvu_done[3] = 1'b1;
        cnt_m[3]++;
        push_bi("t1_done", 8'h00, 8'h08);
        push_cnt("t1", 3);
        push("t1_tmo", S_TMO, 32'd0);
        step();
        repeat (4) begin
            push_bi("t1_hold", 8'h00, 8'h08);
            step();
        end
        irq_ack[3] = 1'b1;
        push_bi("t1_ack", 8'h00, 8'h00);
        step();

        // Watchdog on channel 0 fires 16 cycles after busy rises.
        mvu_start[0] = 1'b1;
        push_bi("t2_start", 8'h01, 8'h00);
        step();
        repeat (15) begin
            push_bi("t2_run", 8'h01, 8'h00);
            push("t2_run_tmo", S_TMO, 32'd0);
            step();
        end
        push_bi("t2_expire", 8'h00, 8'h01);
        push("t2_expire_tmo", S_TMO, 32'h01);
        push_cnt("t2", 0);
        step();
        irq_ack[0] = 1'b1;
        push_bi("t2_ack", 8'h00, 8'h00);
        step();
        mvu_start[0] = 1'b1;
        push_bi("t2_restart", 8'h01, 8'h00);
        push("t2_restart_tmo", S_TMO, 32'd0);
        step();
        mvu_done[0] = 1'b1;
        cnt_m[0]++;
        push_bi("t2_done", 8'h00, 8'h01);
        push_cnt("t2_done", 0);
        step();
        irq_ack[0] = 1'b1;
        step();

        // Channel 6: done lands in the same cycle the watchdog would expire.
        mvu_start[6] = 1'b1;
        push_bi("tie_start", 8'h40, 8'h00);
        step();
        repeat (15) begin
            push_bi("tie_run", 8'h40, 8'h00);
            step();
        end
        mvu_done[6] = 1'b1;
        cnt_m[6]++;
        push_bi("tie_done", 8'h00, 8'h40);
        push("tie_tmo", S_TMO, 32'd0);
        push_cnt("tie", 6);
        step();
        irq_ack[6] = 1'b1;
        push_bi("tie_ack", 8'h00, 8'h00);
        step();

        // Spurious done on idle channel 5, sticky, clear, set-beats-clear.
        mvu_done[5] = 1'b1;
        push("t3_set", S_SPUR, 32'h20);
        step();
        push("t3_sticky", S_SPUR, 32'h20);
        step();
        err_clr[5] = 1'b1;
        push("t3_clr", S_SPUR, 32'h00);
        step();
        mvu_done[5] = 1'b1;
        err_clr[5]  = 1'b1;
        push("t3_setclr", S_SPUR, 32'h20);
        step();
        err_clr[5] = 1'b1;
        push("t3_clr2", S_SPUR, 32'h00);
        step();

        // Channel 2: back-to-back relaunch, then restart while busy.
        mvu_start[2] = 1'b1;
        push_bi("t4_start", 8'h04, 8'h00);
        step();
        mvu_done[2] = 1'b1;
        cnt_m[2]++;
        push_bi("t4_done", 8'h00, 8'h04);
        step();
        irq_ack[2]   = 1'b1;
        mvu_start[2] = 1'b1;
        push_bi("t4_b2b", 8'h04, 8'h00);
        push("t4_b2b_rst", S_RST, 32'h00);
        step();
        mvu_start[2] = 1'b1;
        push_bi("t4_restart", 8'h04, 8'h00);
        push("t4_restart_err", S_RST, 32'h04);
        step();
        mvu_done[2] = 1'b1;
        cnt_m[2]++;
        push_bi("t4_done2", 8'h00, 8'h04);
        push_cnt("t4", 2);
        step();
        irq_ack[2] = 1'b1;
        err_clr[2] = 1'b1;
        push_bi("t4_ack", 8'h00, 8'h00);
        push("t4_clr", S_RST, 32'h00);
        step();

        // All channels launched together, completed in reverse order.
        mvu_start = 8'hFF;
        busy_m = 8'hFF;
        irq_m  = 8'h00;
        push_bi("t5_start", busy_m, irq_m);
        step();
        for (int i = N - 1; i >= 0; i--) begin
            mvu_done[i] = 1'b1;
            busy_m[i] = 1'b0;
            irq_m[i]  = 1'b1;
            cnt_m[i]  = (cnt_m[i] + 1) % (1 << CW);
            push_bi($sformatf("t5_done%0d", i), busy_m, irq_m);
            push_cnt("t5", i);
            step();
        end
        irq_ack = 8'hFF;
        push_bi("t5_ack", 8'h00, 8'h00);
        push("t5_tmo", S_TMO, 32'd0);
        step();

        // Reset while jobs are in flight clears everything.
        mvu_start[1] = 1'b1;
        mvu_start[4] = 1'b1;
        push_bi("t5_busy", 8'h12, 8'h00);
        step();
        rst = 1'b1;
        push_all_zero("t5_rst");
        step();
        rst = 1'b0;
        push_bi("t5_post_rst", 8'h00, 8'h00);
        step();

        // 17 jobs on channel 1 wrap the 4-bit counter to 1.
        for (int k = 0; k < 17; k++) begin
            mvu_start[1] = 1'b1;
            push_bi("t6_start", 8'h02, 8'h00);
            step();
            mvu_done[1] = 1'b1;
            cnt_m[1] = (cnt_m[1] + 1) % (1 << CW);
            push("t6_irq", S_IRQ, 32'h02);
            push_cnt("t6", 1);
            step();
            irq_ack[1] = 1'b1;
            push("t6_ack", S_IRQ, 32'h00);
            step();
        end
        push("t6_wrap", S_CNT + 1, 32'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
